// File: rtl/lce_run_monitor.sv
// Run controller and end-of-test monitor: warm-up, cycle/instruction counting, end-of-run event
// arbitration with latched results, and sticky per-hart branch-suppression control.
module lce_run_monitor #(
  parameter int unsigned NUM_HARTS     = 1,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned PC_W          = 32,
  parameter int unsigned WARMUP_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic [CNT_W-1:0]           max_cycles_i,
  input  logic                       lce_en_i,
  input  logic [CNT_W-1:0]           lce_delay_i,
  input  logic [NUM_HARTS-1:0]       instr_valid_i,
  input  logic [NUM_HARTS*PC_W-1:0]  pc_if_i,
  input  logic [NUM_HARTS-1:0]       alarm_i,
  input  logic                       tests_passed_i,
  input  logic                       tests_failed_i,
  input  logic                       exit_valid_i,
  input  logic [31:0]                exit_value_i,
  output logic [NUM_HARTS-1:0]       pc_set_block_o,
  output logic                       done_o,
  output logic [2:0]                 status_o,
  output logic [CNT_W-1:0]           final_cycle_o,
  output logic [PC_W-1:0]            final_pc_o,
  output logic [2:0]                 final_hart_o,
  output logic [31:0]                exit_code_o,
  output logic [NUM_HARTS*CNT_W-1:0] instr_count_o,
  output logic [CNT_W-1:0]           cycle_cnt_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWarmup = 2'd1;
  localparam logic [1:0] StRun    = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [2:0] StsNone    = 3'd0;
  localparam logic [2:0] StsPass    = 3'd1;
  localparam logic [2:0] StsFail    = 3'd2;
  localparam logic [2:0] StsExitOk  = 3'd3;
  localparam logic [2:0] StsExitErr = 3'd4;
  localparam logic [2:0] StsTimeout = 3'd5;
  localparam logic [2:0] StsAlarm   = 3'd6;

  localparam logic [7:0] WarmLast = 8'((WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1);

  logic [1:0]                 state_q, state_d;
  logic [7:0]                 warm_q, warm_d;
  logic [CNT_W-1:0]           cycle_q, cycle_d;
  logic [NUM_HARTS*CNT_W-1:0] instr_q, instr_d;
  logic                       done_q, done_d;
  logic [2:0]                 status_q, status_d;
  logic [CNT_W-1:0]           fcycle_q, fcycle_d;
  logic [PC_W-1:0]            fpc_q, fpc_d;
  logic [2:0]                 fhart_q, fhart_d;
  logic [31:0]                code_q, code_d;
  logic                       block_q, block_d;

  logic                       active, timeout, alarm_hit, ev_fire;
  logic [2:0]                 alarm_hart, ev_status, ev_hart;
  logic [PC_W-1:0]            ev_pc;

  assign active  = (state_q == StWarmup) || (state_q == StRun);
  assign timeout = (state_q == StRun) && (max_cycles_i != '0) && (cycle_q >= max_cycles_i);

  // Downward scan so the lowest alarming hart wins.
  always_comb begin
    alarm_hit  = 1'b0;
    alarm_hart = 3'd0;
    for (int h = int'(NUM_HARTS) - 1; h >= 0; h--) begin
      if (alarm_i[h]) begin
        alarm_hit  = 1'b1;
        alarm_hart = 3'(h);
      end
    end
  end

  always_comb begin
    ev_status = StsNone;
    if (alarm_hit)           ev_status = StsAlarm;
    else if (tests_failed_i) ev_status = StsFail;
    else if (tests_passed_i) ev_status = StsPass;
    else if (exit_valid_i)   ev_status = (exit_value_i == 32'd0) ? StsExitOk : StsExitErr;
    else if (timeout)        ev_status = StsTimeout;
  end

  assign ev_fire = active && (ev_status != StsNone);
  assign ev_hart = alarm_hit ? alarm_hart : 3'd0;

  always_comb begin
    ev_pc = '0;
    for (int h = 0; h < int'(NUM_HARTS); h++) begin
      if (ev_hart == 3'(h)) ev_pc = pc_if_i[h*PC_W +: PC_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    cycle_d  = cycle_q;
    done_d   = done_q;
    status_d = status_q;
    fcycle_d = fcycle_q;
    fpc_d    = fpc_q;
    fhart_d  = fhart_q;
    code_d   = code_q;
    unique case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = (WARMUP_CYCLES == 0) ? StRun : StWarmup;
          warm_d  = 8'd0;
        end
      end
      StWarmup: begin
        if (ev_fire) begin
          state_d = StDone;
        end else if (warm_q == WarmLast) begin
          state_d = StRun;
        end else begin
          warm_d = warm_q + 8'd1;
        end
      end
      StRun: begin
        if (ev_fire) begin
          state_d = StDone;
        end else if (cycle_q != '1) begin
          cycle_d = cycle_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (ev_fire) begin
      done_d   = 1'b1;
      status_d = ev_status;
      fcycle_d = cycle_q;
      fpc_d    = ev_pc;
      fhart_d  = ev_hart;
      code_d   = ((ev_status == StsExitOk) || (ev_status == StsExitErr)) ? exit_value_i : 32'd0;
    end
  end

  always_comb begin
    instr_d = instr_q;
    for (int h = 0; h < int'(NUM_HARTS); h++) begin
      if (active && instr_valid_i[h] && (instr_q[h*CNT_W +: CNT_W] != '1)) begin
        instr_d[h*CNT_W +: CNT_W] = instr_q[h*CNT_W +: CNT_W] + 1'b1;
      end
    end
  end

  // Sticky once set; only reset clears the suppression request.
  assign block_d = block_q | (lce_en_i && ((state_q == StRun) || (state_q == StDone)) &&
                              (cycle_q >= lce_delay_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      warm_q   <= 8'd0;
      cycle_q  <= '0;
      instr_q  <= '0;
      done_q   <= 1'b0;
      status_q <= StsNone;
      fcycle_q <= '0;
      fpc_q    <= '0;
      fhart_q  <= 3'd0;
      code_q   <= 32'd0;
      block_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
      done_q   <= done_d;
      status_q <= status_d;
      fcycle_q <= fcycle_d;
      fpc_q    <= fpc_d;
      fhart_q  <= fhart_d;
      code_q   <= code_d;
      block_q  <= block_d;
    end
  end

  assign pc_set_block_o = {NUM_HARTS{block_q}};
  assign done_o         = done_q;
  assign status_o       = status_q;
  assign final_cycle_o  = fcycle_q;
  assign final_pc_o     = fpc_q;
  assign final_hart_o   = fhart_q;
  assign exit_code_o    = code_q;
  assign instr_count_o  = instr_q;
  assign cycle_cnt_o    = cycle_q;

endmodule

// File: tb/tb_lce_run_monitor.sv
// Randomized bench for lce_run_monitor with a behavioural run model and directed end-of-run checks.
module tb_lce_run_monitor;

  localparam int unsigned NH   = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned PW   = 32;
  localparam int unsigned WU   = 2;
  localparam int          CMAX = 255;
  localparam int          EnAt = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [CW-1:0]     max_cycles;
  logic              lce_en;
  logic [CW-1:0]     lce_delay;
  logic [NH-1:0]     instr_valid;
  logic [NH*PW-1:0]  pc_if;
  logic [NH-1:0]     alarm;
  logic              tests_passed, tests_failed, exit_valid;
  logic [31:0]       exit_value;
  logic [NH-1:0]     pc_set_block;
  logic              done;
  logic [2:0]        status, final_hart;
  logic [CW-1:0]     final_cycle, cycle_cnt;
  logic [PW-1:0]     final_pc;
  logic [31:0]       exit_code;
  logic [NH*CW-1:0]  instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: phase 0 idle, 1 warm-up, 2 run, 3 done.
  int          m_phase, m_wu, m_cyc, m_status, m_fcyc, m_fhart;
  int          m_instr[NH];
  logic [31:0] m_fpc, m_code;
  bit          m_done, m_block;

  always #5 clk = ~clk;

  lce_run_monitor #(
    .NUM_HARTS    (NH),
    .CNT_W        (CW),
    .PC_W         (PW),
    .WARMUP_CYCLES(WU)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .max_cycles_i  (max_cycles),
    .lce_en_i      (lce_en),
    .lce_delay_i   (lce_delay),
    .instr_valid_i (instr_valid),
    .pc_if_i       (pc_if),
    .alarm_i       (alarm),
    .tests_passed_i(tests_passed),
    .tests_failed_i(tests_failed),
    .exit_valid_i  (exit_valid),
    .exit_value_i  (exit_value),
    .pc_set_block_o(pc_set_block),
    .done_o        (done),
    .status_o      (status),
    .final_cycle_o (final_cycle),
    .final_pc_o    (final_pc),
    .final_hart_o  (final_hart),
    .exit_code_o   (exit_code),
    .instr_count_o (instr_count),
    .cycle_cnt_o   (cycle_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_wu = 0; m_cyc = 0; m_status = 0; m_fcyc = 0; m_fhart = 0;
    m_fpc = 0; m_code = 0; m_done = 0; m_block = 0;
    for (int h = 0; h < NH; h++) m_instr[h] = 0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    int st, hart;
    if ((m_phase >= 2) && lce_en && (m_cyc >= int'(lce_delay))) m_block = 1;
    if (m_phase == 0) begin
      if (enable) m_phase = (WU == 0) ? 2 : 1;
      m_wu = 0;
    end else if (m_phase != 3) begin
      for (int h = 0; h < NH; h++) if (instr_valid[h] && m_instr[h] < CMAX) m_instr[h]++;
      st = 0; hart = 0;
      for (int h = NH - 1; h >= 0; h--) if (alarm[h]) begin st = 6; hart = h; end
      if (st == 0) begin
        if (tests_failed) st = 2;
        else if (tests_passed) st = 1;
        else if (exit_valid) st = (exit_value == 0) ? 3 : 4;
        else if (m_phase == 2 && max_cycles != 0 && m_cyc >= int'(max_cycles)) st = 5;
      end
      if (st != 0) begin
        m_done = 1; m_status = st; m_fcyc = m_cyc; m_fhart = hart;
        m_fpc = pc_if[hart*PW +: PW];
        m_code = (st == 3 || st == 4) ? exit_value : 32'd0;
        m_phase = 3;
      end else if (m_phase == 1) begin
        m_wu++;
        if (m_wu == WU) m_phase = 2;
      end else if (m_cyc < CMAX) begin
        m_cyc++;
      end
    end
  endtask

  task automatic check_all();
    check("done", 64'(done), 64'(m_done));
    check("status", 64'(status), 64'(m_status));
    check("final_cycle", 64'(final_cycle), 64'(m_fcyc));
    check("final_pc", 64'(final_pc), 64'(m_fpc));
    check("final_hart", 64'(final_hart), 64'(m_fhart));
    check("exit_code", 64'(exit_code), 64'(m_code));
    check("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
    check("pc_set_block", 64'(pc_set_block), m_block ? 64'hF : 64'h0);
    for (int h = 0; h < NH; h++)
      check($sformatf("instr%0d", h), 64'(instr_count[h*CW +: CW]), 64'(m_instr[h]));
  endtask

  task automatic zero_inputs();
    enable = 0; instr_valid = '0; pc_if = '0; alarm = '0;
    tests_passed = 0; tests_failed = 0; exit_valid = 0; exit_value = '0;
  endtask

  // fev: 0 none, 1 pass, 2 alarm 4'b1010 with fail, 3 exit 7, 4 exit 0; applied at cycle_cnt==fat.
  task automatic run(input int ncyc, input int maxc, input bit len, input int dly, input int rate,
                     input int fev, input int fat, input int rst_at, input bit hold_valid,
                     input int exp_st, input int exp_fcyc, input int exp_hart, input int exp_lat);
    bit forced = 0;
    int done_at = -1;
    rst_n = 0;
    zero_inputs();
    max_cycles = CW'(maxc); lce_en = len; lce_delay = CW'(dly);
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check_all();
      if (done && done_at < 0) done_at = i;
      if (i == rst_at) begin
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        return;
      end
      enable      = (i == EnAt) || (i > EnAt && $urandom_range(0, 3) == 0);
      instr_valid = hold_valid ? {NH{1'b1}} : NH'($urandom);
      pc_if       = {$urandom, $urandom, $urandom, $urandom};
      exit_value  = $urandom_range(0, 3);
      if (i < EnAt) begin
        alarm = NH'($urandom); tests_failed = 1'($urandom);
        tests_passed = 1'($urandom); exit_valid = 1'($urandom);
      end else begin
        for (int h = 0; h < NH; h++) alarm[h] = (rate > 0) && ($urandom_range(0, rate*4-1) == 0);
        tests_failed = (rate > 0) && ($urandom_range(0, rate-1) == 0);
        tests_passed = (rate > 0) && ($urandom_range(0, rate-1) == 0);
        exit_valid   = (rate > 0) && ($urandom_range(0, rate-1) == 0);
      end
      if (fev != 0 && !forced && m_phase == 2 && m_cyc == fat) begin
        forced = 1;
        alarm = '0; tests_failed = 0; tests_passed = 0; exit_valid = 0;
        case (fev)
          1: tests_passed = 1;
          2: begin alarm = 4'b1010; tests_failed = 1; end
          3: begin exit_valid = 1; exit_value = 32'd7; end
          default: begin exit_valid = 1; exit_value = 32'd0; end
        endcase
      end
      model_step();
    end
    @(negedge clk);
    check_all();
    if (exp_st >= 0)   check("status_end", 64'(status), 64'(exp_st));
    if (exp_fcyc >= 0) check("final_cycle_end", 64'(final_cycle), 64'(exp_fcyc));
    if (exp_hart >= 0) check("final_hart_end", 64'(final_hart), 64'(exp_hart));
    if (exp_lat >= 0)  check("done_latency", 64'(done_at - EnAt - 1), 64'(exp_lat));
  endtask

  initial begin
    rst_n = 0;
    zero_inputs();
    max_cycles = '0; lce_en = 0; lce_delay = '0;
    model_reset();
    #1;
    check_all();
    // pass at cycle 100, suppression from cycle 10
    run(120, 0, 1, 10, 0, 1, 100, -1, 0, 1, 100, 0, -1);
    // timeout at 50: done 53 edges after the enable edge
    run(80, 50, 0, 0, 0, 0, 0, -1, 0, 5, 50, 0, 53);
    // alarm on harts 1 and 3 beats a same-cycle fail
    run(40, 0, 1, 0, 0, 2, 15, -1, 0, 6, 15, 1, -1);
    run(30, 0, 0, 0, 0, 3, 5, -1, 0, 4, 5, 0, -1);
    check("exit_code_7", 64'(exit_code), 64'd7);
    run(30, 0, 0, 0, 0, 4, 5, -1, 0, 3, 5, 0, -1);
    // counters saturate at 255
    run(300, 0, 1, 200, 0, 0, 0, -1, 1, 0, -1, -1, -1);
    check("cycle_sat", 64'(cycle_cnt), 64'd255);
    check("instr_sat", 64'(instr_count), 64'hFFFF_FFFF);
    // asynchronous reset mid-run
    run(60, 0, 1, 5, 0, 0, 0, 40, 0, -1, -1, -1, -1);
    for (int r = 0; r < 20; r++) begin
      run(150, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(10, 120)),
          1'($urandom), int'($urandom_range(0, 40)), 30, 0, 0, -1, 0, -1, -1, -1, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
